// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_pkg
// Brief    : Shared types and helpers for the operand-bypass select generator.
// Revision : 1.0
// ============================================================================
package fwd_pkg;

    typedef logic [4:0] reg_idx_t;
    typedef logic [3:0] fwd_sel_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t dreg;
        logic     ready;
    } fwd_entry_t;

    localparam fwd_sel_t SEL_RF     = 4'd0;
    localparam int       DEF_NLANE  = 3;
    localparam int       DEF_NSTAGE = 3;

    // Bypass source code: 0 is the register file, sources count up from 1.
    function automatic fwd_sel_t sel_code(input int stage, input int lane, input int nlane);
        return fwd_sel_t'(1 + stage * nlane + lane);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_match.sv
`default_nettype none
// ============================================================================
// Module   : fwd_match
// Brief    : Priority encoder finding the youngest history entry for rd_reg.
// Revision : 1.0
// ============================================================================
module fwd_match
    import fwd_pkg::*;
#(
    parameter  int NLANE  = DEF_NLANE,
    parameter  int NSTAGE = DEF_NSTAGE,
    localparam int SW     = idx_w(NSTAGE),
    localparam int LW     = idx_w(NLANE)
) (
    input  fwd_entry_t [NSTAGE*NLANE-1:0] hist,
    input  reg_idx_t                      rd_reg,
    output logic                          hit,
    output logic [SW-1:0]                 stage,
    output logic [LW-1:0]                 lane,
    output logic                          ready
);

    // Scan oldest-to-youngest so the last assignment (lowest stage, highest lane) wins.
    always_comb begin
        hit   = 1'b0;
        stage = '0;
        lane  = '0;
        ready = 1'b0;
        for (int s = NSTAGE - 1; s >= 0; s--) begin
            for (int l = 0; l < NLANE; l++) begin
                if (hist[s*NLANE+l].valid && (hist[s*NLANE+l].dreg == rd_reg) &&
                    (rd_reg != '0)) begin
                    hit   = 1'b1;
                    stage = SW'(s);
                    lane  = LW'(l);
                    ready = hist[s*NLANE+l].ready;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_sel_gen.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel_gen
// Brief    : Destination-register history and registered bypass-mux select.
// Revision : 1.0
// ============================================================================
module fwd_sel_gen
    import fwd_pkg::*;
#(
    parameter int NLANE       = DEF_NLANE,
    parameter int NSTAGE      = DEF_NSTAGE,
    parameter int READY_STAGE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic [NLANE-1:0]   wr_valid,
    input  logic [NLANE*5-1:0] wr_reg,
    input  logic [NLANE-1:0]   wr_ready,
    input  logic               rd_valid,
    input  logic [4:0]         rd_reg,
    output logic [3:0]         sel,
    output logic               sel_valid,
    output logic               hazard
);

    localparam int SW = idx_w(NSTAGE);
    localparam int LW = idx_w(NLANE);

    fwd_entry_t [NSTAGE*NLANE-1:0] r_hist;
    fwd_entry_t [NSTAGE*NLANE-1:0] w_hist_nxt;

    logic          w_hit;
    logic          w_ready;
    logic [SW-1:0] w_stage;
    logic [LW-1:0] w_lane;
    fwd_sel_t      w_sel;

    fwd_sel_t      r_sel;
    logic          r_sel_valid;
    logic          r_hazard;

    // Shifted history; register 0 is stored invalid so it can never be forwarded.
    always_comb begin
        w_hist_nxt = r_hist;
        for (int l = 0; l < NLANE; l++) begin
            w_hist_nxt[l].valid = wr_valid[l] && (wr_reg[l*5 +: 5] != 5'd0);
            w_hist_nxt[l].dreg  = wr_reg[l*5 +: 5];
            w_hist_nxt[l].ready = (READY_STAGE <= 0) ? 1'b1 : wr_ready[l];
        end
        for (int s = 1; s < NSTAGE; s++) begin
            for (int l = 0; l < NLANE; l++) begin
                w_hist_nxt[s*NLANE+l] = r_hist[(s-1)*NLANE+l];
                if (s >= READY_STAGE) begin
                    w_hist_nxt[s*NLANE+l].ready = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_hist <= '0;
        end else if (!stall) begin
            r_hist <= w_hist_nxt;
        end
    end

    fwd_match #(
        .NLANE  (NLANE),
        .NSTAGE (NSTAGE)
    ) u_match (
        .hist   (r_hist),
        .rd_reg (rd_reg),
        .hit    (w_hit),
        .stage  (w_stage),
        .lane   (w_lane),
        .ready  (w_ready)
    );

    assign w_sel = w_hit ? sel_code(int'(w_stage), int'(w_lane), NLANE) : SEL_RF;

    // Lookups keep updating through stall and flush; only the history freezes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel       <= SEL_RF;
            r_sel_valid <= 1'b0;
            r_hazard    <= 1'b0;
        end else begin
            r_sel       <= rd_valid ? w_sel : SEL_RF;
            r_sel_valid <= rd_valid;
            r_hazard    <= rd_valid && w_hit && !w_ready;
        end
    end

    assign sel       = r_sel;
    assign sel_valid = r_sel_valid;
    assign hazard    = r_hazard;

endmodule
`default_nettype wire

// File: tb/tb_fwd_sel_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_sel_gen
// Brief    : Directed bench for fwd_sel_gen with an age-list reference model.
// Revision : 1.0
// ============================================================================
module tb_fwd_sel_gen;
    import fwd_pkg::*;

    localparam int NLANE       = 3;
    localparam int NSTAGE      = 3;
    localparam int READY_STAGE = 1;

    logic        clk = 1'b0;
    logic        reset, stall, flush, rd_valid;
    logic [2:0]  wr_valid, wr_ready;
    logic [14:0] wr_reg;
    logic [4:0]  rd_reg;
    logic [3:0]  sel;
    logic        sel_valid, hazard;

    always #5 clk = ~clk;

    fwd_sel_gen #(
        .NLANE       (NLANE),
        .NSTAGE      (NSTAGE),
        .READY_STAGE (READY_STAGE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .wr_valid  (wr_valid),
        .wr_reg    (wr_reg),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_reg    (rd_reg),
        .sel       (sel),
        .sel_valid (sel_valid),
        .hazard    (hazard)
    );

    // Model: a flat list of live writes, each tagged with how many advances it has seen.
    typedef struct {
        int rg;
        int lane;
        bit rdy;
        int age;
    } rec_t;

    rec_t hist_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   checking = 1'b0;
    int   exp_sel = 0, pend_sel = 0;
    bit   exp_sv = 1'b0, exp_hz = 1'b0, pend_sv = 1'b0, pend_hz = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic model_predict();
        int best;
        best     = -1;
        pend_sv  = !reset && rd_valid;
        pend_sel = 0;
        pend_hz  = 1'b0;
        if (!reset && rd_valid && rd_reg != 5'd0) begin
            foreach (hist_q[i]) begin
                if (hist_q[i].rg == int'(rd_reg)) begin
                    if (best < 0 || hist_q[i].age < hist_q[best].age ||
                        (hist_q[i].age == hist_q[best].age && hist_q[i].lane > hist_q[best].lane))
                        best = i;
                end
            end
            if (best >= 0) begin
                pend_sel = 1 + hist_q[best].age * NLANE + hist_q[best].lane;
                pend_hz  = !(hist_q[best].rdy || hist_q[best].age >= READY_STAGE);
            end
        end
    endtask

    task automatic model_advance();
        rec_t nq[$];
        rec_t r;
        if (reset || flush) begin
            hist_q.delete();
        end else if (!stall) begin
            foreach (hist_q[i]) begin
                if (hist_q[i].age + 1 < NSTAGE) begin
                    r = hist_q[i];
                    r.age++;
                    nq.push_back(r);
                end
            end
            for (int l = 0; l < NLANE; l++) begin
                if (wr_valid[l] && wr_reg[l*5 +: 5] != 5'd0)
                    nq.push_back('{rg: int'(wr_reg[l*5 +: 5]), lane: l, rdy: wr_ready[l], age: 0});
            end
            hist_q = nq;
        end
    endtask

    task automatic step(input bit rs, input bit st, input bit fl,
                        input logic [2:0] wv, input logic [14:0] wr, input logic [2:0] wy,
                        input bit rv, input logic [4:0] rr);
        reset    = rs;
        stall    = st;
        flush    = fl;
        wr_valid = wv;
        wr_reg   = wr;
        wr_ready = wy;
        rd_valid = rv;
        rd_reg   = rr;
        model_predict();
        model_advance();
        @(posedge clk);
        exp_sel  = pend_sel;
        exp_sv   = pend_sv;
        exp_hz   = pend_hz;
        checking = 1'b1;
        #1;
    endtask

    // Hand-computed values pin both the DUT and the model.
    task automatic lit(input string nm, input int s, input bit v, input bit h);
        chk({nm, "_sel"}, 32'(sel), 32'(s));
        chk({nm, "_valid"}, 32'(sel_valid), 32'(v));
        chk({nm, "_hazard"}, 32'(hazard), 32'(h));
        chk({nm, "_model"}, 32'(exp_sel), 32'(s));
    endtask

    function automatic logic [14:0] pk(input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] r0);
        return {r2, r1, r0};
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            chk("cyc_sel", 32'(sel), 32'(exp_sel));
            chk("cyc_valid", 32'(sel_valid), 32'(exp_sv));
            chk("cyc_hazard", 32'(hazard), 32'(exp_hz));
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; rd_valid = 1'b0; rd_reg = '0;
        wr_valid = '0; wr_reg = '0; wr_ready = '0;

        step(1, 0, 0, 3'b111, pk(5, 5, 5), 3'b111, 0, 0); lit("rst0", 0, 0, 0);
        step(1, 0, 0, 3'b111, pk(5, 5, 5), 3'b111, 0, 0); lit("rst1", 0, 0, 0);
        step(0, 0, 0, 3'b000, 15'd0, 3'b000, 1, 5);        lit("empty_r5", 0, 1, 0);

        step(0, 0, 0, 3'b010, pk(0, 5, 0), 3'b010, 0, 0);
        step(0, 0, 0, 3'b000, 15'd0, 3'b000, 1, 5);        lit("r5_s0", 2, 1, 0);
        step(0, 0, 0, 3'b000, 15'd0, 3'b000, 1, 5);        lit("r5_s1", 5, 1, 0);
        step(0, 0, 0, 3'b000, 15'd0, 3'b000, 1, 5);        lit("r5_s2", 8, 1, 0);
        step(0, 0, 0, 3'b000, 15'd0, 3'b000, 1, 5);        lit("r5_gone", 0, 1, 0);

        step(0, 0, 0, 3'b101, pk(7, 0, 7), 3'b101, 0, 0);
        step(0, 0, 0, 3'b001, pk(0, 0, 7), 3'b001, 1, 7);  lit("r7_lane2", 3, 1, 0);
        step(0, 0, 0, 3'b000, 15'd0, 3'b000, 1, 7);        lit("r7_stage0", 1, 1, 0);

        step(0, 0, 0, 3'b100, pk(9, 0, 0), 3'b000, 0, 0);
        step(0, 1, 0, 3'b000, 15'd0, 3'b000, 1, 9);        lit("r9_stall0", 3, 1, 1);
        step(0, 1, 0, 3'b111, pk(9, 9, 9), 3'b111, 1, 9);  lit("r9_stall1", 3, 1, 1);
        step(0, 0, 0, 3'b000, 15'd0, 3'b000, 1, 9);        lit("r9_release", 3, 1, 1);
        step(0, 0, 0, 3'b000, 15'd0, 3'b000, 1, 9);        lit("r9_aged", 6, 1, 0);

        step(0, 0, 0, 3'b001, pk(0, 0, 0), 3'b001, 0, 0);
        step(0, 0, 0, 3'b000, 15'd0, 3'b000, 1, 0);        lit("r0", 0, 1, 0);
        step(0, 0, 0, 3'b000, 15'd0, 3'b000, 0, 4);        lit("no_rd", 0, 0, 0);

        step(0, 0, 0, 3'b001, pk(0, 0, 11), 3'b001, 0, 0);
        step(0, 0, 0, 3'b001, pk(0, 0, 11), 3'b000, 1, 11); lit("r11_ready", 1, 1, 0);
        step(0, 0, 0, 3'b000, 15'd0, 3'b000, 1, 11);        lit("r11_young", 1, 1, 1);

        step(0, 0, 0, 3'b010, pk(0, 3, 0), 3'b010, 0, 0);
        step(0, 0, 0, 3'b010, pk(0, 3, 0), 3'b010, 0, 0);
        step(0, 0, 0, 3'b010, pk(0, 3, 0), 3'b010, 0, 0);
        step(0, 0, 1, 3'b010, pk(0, 3, 0), 3'b010, 1, 3);  lit("flush_pre", 2, 1, 0);
        step(0, 0, 0, 3'b000, 15'd0, 3'b000, 1, 3);        lit("flush_post", 0, 1, 0);

        step(0, 0, 0, 3'b010, pk(0, 3, 0), 3'b010, 0, 0);
        step(0, 0, 0, 3'b010, pk(0, 3, 0), 3'b010, 0, 0);
        step(0, 1, 1, 3'b010, pk(0, 3, 0), 3'b010, 0, 0);  lit("flush_stall", 0, 0, 0);
        step(0, 0, 0, 3'b000, 15'd0, 3'b000, 1, 3);        lit("fs_post", 0, 1, 0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
